// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchronized input, mid-bit sampling,
// single-cycle data/framing-error strobes, break-tolerant recovery.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] uart_data,
  output logic       new_data,
  output logic       framing_error,
  output logic       rx_busy
);

  // state     | meaning
  // IDLE      | line idle, waiting for rx_s low
  // START     | timing to start-bit middle, rejects glitches
  // DATA      | sampling 8 data bits LSB first
  // STOP      | sampling stop bit, emits strobe
  // WAIT_IDLE | after framing error, wait for line high

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_nx;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic [7:0]    data_nx;
  logic          new_data_nx, framing_error_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      uart_data     <= '0;
      new_data      <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      bit_idx       <= bit_idx_nx;
      shreg         <= shreg_nx;
      uart_data     <= data_nx;
      new_data      <= new_data_nx;
      framing_error <= framing_error_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    cnt_nx           = cnt;
    bit_idx_nx       = bit_idx;
    shreg_nx         = shreg;
    data_nx          = uart_data;
    new_data_nx      = 1'b0;
    framing_error_nx = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx   = START;
          cnt_nx     = '0;
          bit_idx_nx = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nx   = '0;
          state_nx = rx_s ? IDLE : DATA;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = '0;
          // right shift: the first bit received ends up in bit 0
          shreg_nx = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            data_nx     = shreg;
            new_data_nx = 1'b1;
            state_nx    = IDLE;
          end else begin
            framing_error_nx = 1'b1;
            state_nx         = WAIT_IDLE;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz clk, 115200 baud); legal range >= 4.
REQ-002 Parameter HALF_BIT, default CLKS_PER_BIT/2 (integer division), cycles from start-bit detection to the start-bit mid-sample.
REQ-003 Port: clk  input  1  system clock; all logic on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: rx  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-006 Port: uart_data  output  8  last correctly framed byte; feeds the downstream config store directly.
REQ-007 Port: new_data  output  1  single-cycle strobe; uart_data is valid in the same cycle.
REQ-008 Port: framing_error  output  1  single-cycle strobe when the stop bit is sampled low.
REQ-009 Port: rx_busy  output  1  high in every state except IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; the synchronizer resets to 1.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-012 IDLE: the first cycle with rx_s==0 (t0) SHALL enter START and clear the bit counter.
REQ-013 START: at cycle t0+HALF_BIT, rx_s SHALL be sampled; 0 -> DATA; 1 -> IDLE (glitch rejected, no strobe).
REQ-014 DATA: bit n (n=0..7) SHALL be sampled at t0+HALF_BIT+(n+1)*CLKS_PER_BIT into shift-register position n.
REQ-015 STOP: the stop bit SHALL be sampled at ts = t0+HALF_BIT+9*CLKS_PER_BIT.
REQ-016 Stop bit = 1 -> uart_data loads the shift register and new_data=1 in cycle ts+1 only; FSM -> IDLE at ts+1.
REQ-017 Stop bit = 0 -> framing_error=1 in cycle ts+1 only; uart_data unchanged; new_data stays 0; FSM -> WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL remain until rx_s==1, then go to IDLE; a held-low line (break) SHALL yield exactly one framing_error.
REQ-019 Exactly one byte is captured per start bit; back-to-back frames with no idle gap SHALL all be received, because IDLE is re-entered before the next start edge.
REQ-020 Latency: rx falling edge at pin -> new_data = 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles.
REQ-021 uart_data SHALL hold its value between strobes; it never changes outside a new_data cycle.
REQ-022 new_data and framing_error SHALL never be high in the same cycle.
REQ-023 Bit-period counter width SHALL be clog2(CLKS_PER_BIT); the counter SHALL wrap to 0 at each sample point with no cumulative drift.

Reset
REQ-024 While rst=1: FSM=IDLE, counters=0, shift register=0x00, uart_data=0x00, new_data=0, framing_error=0, rx_busy=0, synchronizer flops=1.
REQ-025 rst asserted mid-frame SHALL abort the frame with no strobe; after release, reception restarts only on a fresh falling edge.
REQ-026 rst has priority over every FSM transition in the same cycle.

Verification (CLKS_PER_BIT=16, HALF_BIT=8)
REQ-027 Send 0xDF with a valid stop bit -> new_data pulses once, 2+8+144+1=155 cycles after the start edge, with uart_data=0xDF; framing_error stays 0.
REQ-028 Send 0x00, then 0xFF, then 0xA5 back-to-back with no idle bits -> three new_data pulses, 160 cycles apart, uart_data=0x00, 0xFF, 0xA5 in order.
REQ-029 Drive rx low for 4 cycles, then high (glitch) -> FSM returns to IDLE by t0+8; no new_data; no framing_error; uart_data unchanged.
REQ-030 Send 0x3C with the stop bit low, then hold rx low for 100 cycles, then high -> one framing_error pulse at ts+1; uart_data keeps its prior value; rx_busy stays high until rx_s returns to 1.
REQ-031 Assert rst for 1 cycle during bit 4 of 0x55 -> no strobe; all outputs at reset values; a following 0x81 frame is received correctly.
REQ-032 Send 4 bytes 0xDF into a store_configs instance through this block -> store_configs sees exactly 4 single-cycle new_data pulses carrying 0xDF.
